// File: rtl/fixed_sched_pkg.sv
// Shared types and constants for the fixed-order scheduler: FSM states, order count,
// default encoder latency / accumulator width and the Rice-parameter helpers.
package fixed_sched_pkg;

    localparam int NUM_ORDERS      = 5;
    localparam int DEFAULT_LATENCY = 8;
    localparam int DEFAULT_SUM_W   = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENC_RST = 3'd1,
        FEED    = 3'd2,
        FLUSH   = 3'd3,
        CMP     = 3'd4,
        DONE    = 3'd5
    } state_t;

    // Index of the highest set bit; an all-zero input maps to 0.
    function automatic int msb_index(input logic [63:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < 64; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

    function automatic logic [4:0] rice_param(input logic [63:0] best_sum, input logic [63:0] n);
        int diff;
        diff = msb_index(best_sum) - msb_index(n);
        return (diff <= 0) ? 5'd0 : 5'(diff);
    endfunction

endpackage

// File: rtl/abs_sat_accumulator.sv
// One per-order accumulator: adds |residual| (computed one bit wider so the most negative
// residual has a representable magnitude) and saturates at the all-ones sum.
module abs_sat_accumulator #(
    parameter int SAMPLE_W = 16,
    parameter int SUM_W    = 32
) (
    input  logic                       iClock,
    input  logic                       iReset,
    input  logic                       clear,
    input  logic                       add_en,
    input  logic signed [SAMPLE_W-1:0] residual,
    output logic        [SUM_W-1:0]    sum
);

    localparam int MAG_W = SAMPLE_W + 1;
    localparam int ACC_W = ((SUM_W > MAG_W) ? SUM_W : MAG_W) + 1;
    localparam logic [SUM_W-1:0] SUM_MAX = '1;

    logic [MAG_W-1:0] ext;
    logic [MAG_W-1:0] mag;
    logic [ACC_W-1:0] total;

    // NOTE: every signal written here gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        ext   = {residual[SAMPLE_W-1], residual};
        mag   = residual[SAMPLE_W-1] ? (~ext + 1'b1) : ext;
        total = ACC_W'(sum) + ACC_W'(mag);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iClock) begin
        if (iReset || clear) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= (total > ACC_W'(SUM_MAX)) ? SUM_MAX : total[SUM_W-1:0];
        end
    end

endmodule

// File: rtl/fixed_order_scheduler.sv
// Runs one block through the order-0..4 fixed-predictor encoders and reports the order with
// the smallest |residual| sum. Optional macro FIXED_SCHED_RICE_EN adds the oRiceParam output.
module fixed_order_scheduler
    import fixed_sched_pkg::*;
#(
    parameter int SAMPLE_W  = 16,
    parameter int SUM_W     = DEFAULT_SUM_W,
    parameter int BLK_W     = 16,
    parameter int LATENCY   = DEFAULT_LATENCY,
    parameter int MIN_BLOCK = 16
) (
    input  logic                           iClock,
    input  logic                           iReset,
    input  logic                           iStart,
    input  logic [BLK_W-1:0]               iBlockSize,
    input  logic                           iSampleValid,
    input  logic [SAMPLE_W-1:0]            iSample,
    output logic                           oSampleReady,
    output logic                           oEncReset,
    output logic                           oEncEnable,
    output logic [SAMPLE_W-1:0]            oEncSample,
    input  logic [NUM_ORDERS*SAMPLE_W-1:0] iResiduals,
    output logic                           oBusy,
    output logic                           oDone,
    output logic [2:0]                     oBestOrder,
    output logic [SUM_W-1:0]               oBestSum,
    output logic                           oBlockErr
`ifdef FIXED_SCHED_RICE_EN
    ,
    output logic [4:0]                     oRiceParam
`endif
);

    localparam int EN_W = BLK_W + 1;

    state_t                 state, state_nxt;
    logic [BLK_W-1:0]       blk_size;
    logic [BLK_W-1:0]       in_cnt;
    logic [EN_W-1:0]        en_cnt;
    logic [EN_W-1:0]        sample_idx;
    logic                   rst_hold;
    logic                   blk_err_q;
    logic                   transfer;
    logic                   enc_en;
    logic                   tag_valid;
    logic                   acc_clear;
    logic                   start_ok;
    logic [NUM_ORDERS-1:0]  add_en;
    logic [SUM_W-1:0]       sums [NUM_ORDERS];
    logic [2:0]             min_order;
    logic [SUM_W-1:0]       min_sum;
    logic [2:0]             best_order_q;
    logic [SUM_W-1:0]       best_sum_q;

    assign start_ok     = iStart && (iBlockSize >= BLK_W'(MIN_BLOCK));
    assign oSampleReady = (state == FEED);
    assign transfer     = iSampleValid && oSampleReady;
    // Stalls in FEED leave the encoder pipeline frozen; FLUSH clocks it every cycle.
    assign enc_en       = transfer || (state == FLUSH);
    assign oEncEnable   = enc_en;
    assign oEncSample   = (state == FEED) ? iSample : '0;
    assign oEncReset    = rst_hold || (state == ENC_RST);
    assign oBusy        = (state != IDLE);
    assign oDone        = (state == DONE);
    assign oBestOrder   = best_order_q;
    assign oBestSum     = best_sum_q;
    assign oBlockErr    = blk_err_q;
    assign acc_clear    = (state == ENC_RST);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_ok) state_nxt = ENC_RST;
            ENC_RST: state_nxt = FEED;
            FEED:    if (transfer && (in_cnt == blk_size - 1'b1)) state_nxt = FLUSH;
            FLUSH:   if (en_cnt == {1'b0, blk_size} + EN_W'(LATENCY - 1)) state_nxt = CMP;
            CMP:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state        <= IDLE;
            blk_size     <= '0;
            in_cnt       <= '0;
            en_cnt       <= '0;
            rst_hold     <= 1'b1;
            blk_err_q    <= 1'b0;
            best_order_q <= '0;
            best_sum_q   <= '0;
        end else begin
            state     <= state_nxt;
            rst_hold  <= 1'b0;
            blk_err_q <= (state == IDLE) && iStart && !start_ok;
            if ((state == IDLE) && start_ok) blk_size <= iBlockSize;
            if (state == ENC_RST) begin
                in_cnt <= '0;
                en_cnt <= '0;
            end else begin
                if (transfer) in_cnt <= in_cnt + 1'b1;
                if (enc_en)   en_cnt <= en_cnt + 1'b1;
            end
            if (state == CMP) begin
                best_order_q <= min_order;
                best_sum_q   <= min_sum;
            end
        end
    end

    // Residuals lag the enables by LATENCY; order k ignores its first k warm-up samples.
    assign sample_idx = en_cnt - EN_W'(LATENCY);
    assign tag_valid  = enc_en && (en_cnt >= EN_W'(LATENCY)) && (sample_idx < {1'b0, blk_size});

    for (genvar k = 0; k < NUM_ORDERS; k++) begin : g_acc
        assign add_en[k] = tag_valid && (sample_idx >= EN_W'(k));

        abs_sat_accumulator #(
            .SAMPLE_W (SAMPLE_W),
            .SUM_W    (SUM_W)
        ) u_acc (
            .iClock   (iClock),
            .iReset   (iReset),
            .clear    (acc_clear),
            .add_en   (add_en[k]),
            .residual (iResiduals[k*SAMPLE_W +: SAMPLE_W]),
            .sum      (sums[k])
        );
    end

    // Strict less-than keeps the lowest order on ties.
    always_comb begin
        min_order = '0;
        min_sum   = sums[0];
        for (int k = 1; k < NUM_ORDERS; k++) begin
            if (sums[k] < min_sum) begin
                min_order = 3'(k);
                min_sum   = sums[k];
            end
        end
    end

`ifdef FIXED_SCHED_RICE_EN
    logic [4:0] rice_q;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            rice_q <= '0;
        end else if (state == CMP) begin
            rice_q <= rice_param(64'(min_sum), 64'(blk_size));
        end
    end

    assign oRiceParam = rice_q;
`endif

endmodule

// File: tb/tb_fixed_order_scheduler.sv
// Self-checking bench for fixed_order_scheduler: models the encoder bank, drives directed and
// random blocks, and checks two DUTs (32-bit and 16-bit sums) against a behavioural model.
module tb_fixed_order_scheduler;

    localparam int SAMPLE_W = 16;
    localparam int LATENCY  = 8;
    localparam int NORD     = 5;
    localparam longint CAP32 = 64'hFFFF_FFFF;
    localparam longint CAP16 = 64'hFFFF;

    logic                     iClock = 1'b0;
    logic                     iReset = 1'b1;
    logic                     iStart = 1'b0;
    logic [15:0]              iBlockSize = '0;
    logic                     iSampleValid = 1'b0;
    logic [SAMPLE_W-1:0]      iSample = '0;
    logic [NORD*SAMPLE_W-1:0] res_bus;

    logic        a_ready, a_enc_rst, a_enc_en, a_busy, a_done, a_err;
    logic [15:0] a_enc_sample;
    logic [2:0]  a_order;
    logic [31:0] a_sum;
    logic        b_ready, b_enc_rst, b_enc_en, b_busy, b_done, b_err;
    logic [15:0] b_enc_sample;
    logic [2:0]  b_order;
    logic [15:0] b_sum;
`ifdef FIXED_SCHED_RICE_EN
    logic [4:0]  a_rice, b_rice;
`endif

    fixed_order_scheduler dut_a (
        .iClock(iClock), .iReset(iReset), .iStart(iStart), .iBlockSize(iBlockSize),
        .iSampleValid(iSampleValid), .iSample(iSample), .oSampleReady(a_ready),
        .oEncReset(a_enc_rst), .oEncEnable(a_enc_en), .oEncSample(a_enc_sample),
        .iResiduals(res_bus), .oBusy(a_busy), .oDone(a_done), .oBestOrder(a_order),
        .oBestSum(a_sum), .oBlockErr(a_err)
`ifdef FIXED_SCHED_RICE_EN
        , .oRiceParam(a_rice)
`endif
    );

    fixed_order_scheduler #(.SUM_W(16)) dut_b (
        .iClock(iClock), .iReset(iReset), .iStart(iStart), .iBlockSize(iBlockSize),
        .iSampleValid(iSampleValid), .iSample(iSample), .oSampleReady(b_ready),
        .oEncReset(b_enc_rst), .oEncEnable(b_enc_en), .oEncSample(b_enc_sample),
        .iResiduals(res_bus), .oBusy(b_busy), .oDone(b_done), .oBestOrder(b_order),
        .oBestSum(b_sum), .oBlockErr(b_err)
`ifdef FIXED_SCHED_RICE_EN
        , .oRiceParam(b_rice)
`endif
    );

    always #5 iClock = ~iClock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Encoder bank: order-k k-th difference of the sample stream, visible LATENCY enables later.
    int hist [4];
    logic [NORD*SAMPLE_W-1:0] pipe [LATENCY];

    function automatic logic [NORD*SAMPLE_W-1:0] enc_vec(input int x, input int h1, input int h2,
                                                         input int h3, input int h4);
        logic [NORD*SAMPLE_W-1:0] v;
        v[0*16 +: 16] = 16'(x);
        v[1*16 +: 16] = 16'(x - h1);
        v[2*16 +: 16] = 16'(x - 2*h1 + h2);
        v[3*16 +: 16] = 16'(x - 3*h1 + 3*h2 - h3);
        v[4*16 +: 16] = 16'(x - 4*h1 + 6*h2 - 4*h3 + h4);
        return v;
    endfunction

    always @(posedge iClock) begin
        if (a_enc_rst) begin
            for (int i = 0; i < 4; i++) hist[i] <= 0;
            for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
        end else if (a_enc_en) begin
            pipe[0] <= enc_vec(int'($signed(a_enc_sample)), hist[0], hist[1], hist[2], hist[3]);
            for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
            hist[0] <= int'($signed(a_enc_sample));
            for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
        end
    end

    assign res_bus = pipe[LATENCY-1];

    // Reference model over the whole block, straight from the definition of the sums.
    int blk [$];

    function automatic int binom(input int n, input int r);
        int c;
        c = 1;
        for (int i = 0; i < r; i++) c = c * (n - i) / (i + 1);
        return c;
    endfunction

    function automatic longint ref_sum(input int k, input longint cap);
        longint s;
        s = 0;
        for (int j = k; j < blk.size(); j++) begin
            int r;
            logic signed [15:0] w;
            r = 0;
            for (int i = 0; i <= k; i++)
                r += ((i % 2) ? -1 : 1) * binom(k, i) * blk[j-i];
            w = 16'(r);
            s += (w < 0) ? -longint'(w) : longint'(w);
            if (s > cap) s = cap;
        end
        return s;
    endfunction

    function automatic int ref_msb(input longint v);
        int m;
        m = 0;
        for (int i = 0; i < 64; i++) if (v[i]) m = i;
        return m;
    endfunction

    int     exp_order_a, exp_order_b, exp_rice_a, exp_rice_b;
    longint exp_sum_a, exp_sum_b;

    task automatic compute_expect();
        longint sa, sb;
        exp_order_a = 0; exp_sum_a = ref_sum(0, CAP32);
        exp_order_b = 0; exp_sum_b = ref_sum(0, CAP16);
        for (int k = 1; k < NORD; k++) begin
            sa = ref_sum(k, CAP32);
            sb = ref_sum(k, CAP16);
            if (sa < exp_sum_a) begin exp_sum_a = sa; exp_order_a = k; end
            if (sb < exp_sum_b) begin exp_sum_b = sb; exp_order_b = k; end
        end
        exp_rice_a = ref_msb(exp_sum_a) - ref_msb(longint'(blk.size()));
        exp_rice_b = ref_msb(exp_sum_b) - ref_msb(longint'(blk.size()));
        if (exp_rice_a < 0) exp_rice_a = 0;
        if (exp_rice_b < 0) exp_rice_b = 0;
    endtask

    // Compare process: inputs change just after posedge, so negedge sees settled values.
    int enable_cnt = 0;
    int done_cnt   = 0;
    int err_cnt    = 0;

    always @(negedge iClock) begin
        if (!iReset) begin
            if (a_enc_en) enable_cnt++;
            if (a_err) err_cnt++;
            if (!a_busy) check("idle_quiet", {a_enc_en, a_ready, b_enc_en, b_ready}, 0);
            if (a_enc_en && !a_ready) check("flush_sample_zero", a_enc_sample, 0);
            if (a_done) begin
                done_cnt++;
                check("done_b_aligned", b_done, 1);
                check("best_order_a", a_order, exp_order_a);
                check("best_sum_a", a_sum, exp_sum_a);
                check("best_order_b", b_order, exp_order_b);
                check("best_sum_b", b_sum, exp_sum_b);
`ifdef FIXED_SCHED_RICE_EN
                check("rice_a", a_rice, exp_rice_a);
                check("rice_b", b_rice, exp_rice_b);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    // stall: 0 none, 1 toggle, 2 random. abort_after >= 0 stops feeding after that many transfers.
    task automatic run_block(input int stall, input int abort_after, input bit busy_start);
        int idx, guard, en_base, done_base, err_base, n;
        bit take;
        n = blk.size();
        compute_expect();
        en_base = enable_cnt; done_base = done_cnt; err_base = err_cnt;
        iStart = 1'b1; iBlockSize = 16'(n);
        tick();
        iStart = 1'b0; iBlockSize = '0;
        tick();
        check("busy_after_start", a_busy, 1);
        idx = 0; guard = 0;
        while (idx < n && guard < 2000) begin
            case (stall)
                0:       iSampleValid = 1'b1;
                1:       iSampleValid = guard[0];
                default: iSampleValid = ($urandom_range(0, 3) != 0);
            endcase
            iSample = 16'(blk[idx]);
            iStart  = busy_start && (idx == 3);
            iBlockSize = busy_start ? 16'd4 : 16'd0;
            take = iSampleValid && a_ready;
            tick();
            guard++;
            if (take) idx++;
            if (idx == abort_after) break;
        end
        iSampleValid = 1'b0; iSample = '0; iStart = 1'b0; iBlockSize = '0;
        check("feed_in_budget", guard < 2000, 1);
        if (abort_after >= 0) return;
        guard = 0;
        while (!a_done && guard < 200) begin
            tick();
            guard++;
        end
        check("done_seen", a_done, 1);
        tick();
        check("done_one_cycle", {a_done, a_busy}, 0);
        check("enable_total", enable_cnt - en_base, n + LATENCY);
        check("done_count", done_cnt - done_base, 1);
        check("no_err_while_busy", err_cnt - err_base, 0);
    endtask

    task automatic load_ramp();
        blk.delete();
        for (int i = 0; i < 16; i++) blk.push_back(i);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_enc_reset"}, {a_enc_rst, b_enc_rst}, 2'b11);
        check({tag, "_ctrl"}, {a_ready, a_enc_en, a_busy, a_done, a_err,
                               b_ready, b_enc_en, b_busy, b_done, b_err}, 0);
        check({tag, "_data"}, {a_enc_sample, a_order, a_sum, b_order, b_sum}, 0);
    endtask

    initial begin
        int err_base, done_base;

        #1;
        tick(); tick(); tick();
        check_reset_outputs("reset");
        iReset = 1'b0;
        tick(); tick();

        // Model pins, hand-derived.
        load_ramp();
        check("pin_ramp_o0", ref_sum(0, CAP32), 120);
        check("pin_ramp_o1", ref_sum(1, CAP32), 15);
        check("pin_ramp_o2", ref_sum(2, CAP32), 0);

        // Ramp, no stalls: order 2 with sum 0.
        run_block(0, -1, 1'b0);
        check("ramp_order_lit", a_order, 2);
        check("ramp_sum_lit", a_sum, 0);

        // Constant 100: order 1 wins the tie with 2..4.
        blk.delete();
        for (int i = 0; i < 16; i++) blk.push_back(100);
        check("pin_const_o0", ref_sum(0, CAP32), 1600);
        run_block(0, -1, 1'b0);
        check("const_order_lit", a_order, 1);

        // Ramp with valid toggling, plus an ignored iStart mid-block.
        load_ramp();
        run_block(1, -1, 1'b1);
        check("ramp_stall_order_lit", a_order, 2);

        // Undersized block: error pulse, nothing else moves.
        err_base = err_cnt;
        iStart = 1'b1; iBlockSize = 16'd4;
        tick();
        iStart = 1'b0; iBlockSize = '0;
        for (int i = 0; i < 5; i++) begin
            check("short_blk_quiet", {a_busy, a_enc_rst}, 0);
            tick();
        end
        check("short_blk_err_pulses", err_cnt - err_base, 1);

        // Reset after 7 samples: abort without oDone, then a normal block.
        load_ramp();
        done_base = done_cnt;
        run_block(0, 7, 1'b0);
        iReset = 1'b1;
        tick(); tick();
        check_reset_outputs("abort");
        iReset = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        check("abort_no_done", done_cnt - done_base, 0);
        load_ramp();
        run_block(0, -1, 1'b0);
        check("after_abort_order_lit", a_order, 2);

        // All -32768: order 0 saturates the 16-bit sum, order 1 wins with 0.
        blk.delete();
        for (int i = 0; i < 16; i++) blk.push_back(-32768);
        check("pin_sat16_o0", ref_sum(0, CAP16), 65535);
        run_block(2, -1, 1'b0);
        check("sat_order_b_lit", b_order, 1);
        check("sat_sum_b_lit", b_sum, 0);

        // Random blocks, mixed amplitudes and stall patterns.
        for (int t = 0; t < 12; t++) begin
            int n, amp;
            n = $urandom_range(16, 40);
            amp = (t % 2) ? 32767 : $urandom_range(1, 1500);
            blk.delete();
            for (int i = 0; i < n; i++) blk.push_back($urandom_range(0, 2*amp) - amp);
            run_block($urandom_range(0, 2), -1, (t % 3) == 0);
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
